// File: rtl/lelbc_round_fn.sv
// lelbc_round_fn: one registered round of the LELBC 64-bit block cipher
// with a 128-bit key. Each enabled cycle computes the next cipher state
// (AddRoundKey, 4-bit S-box layer, bit permutation) and the next key
// register (rotate, S-box on top byte, round-counter XOR).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, clears both outputs
//   en         update enable; outputs load only when high
//   state_in   [0:63]  current cipher state, bit 0 is the MSB
//   key_in     [0:127] current key register, bit 0 is the MSB
//   round      [0:4]   round counter, bit 0 is the MSB
//   state_out  [0:63]  registered next state
//   key_out    [0:127] registered next key
module lelbc_round_fn (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [0:63]  state_in,
  input  logic [0:127] key_in,
  input  logic [0:4]   round,
  output logic [0:63]  state_out,
  output logic [0:127] key_out
);

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Working copies are declared [W-1:0]; whole-vector assignment from the
  // [0:W-1] ports maps port bit 0 onto the LSB-based bit W-1, so internal
  // index j is exactly the LSB-based bit b(j).
  logic [63:0]  s_in;
  logic [127:0] k_in;
  logic [4:0]   rnd;

  assign s_in = state_in;
  assign k_in = key_in;
  assign rnd  = round;

  logic [63:0]  ark;
  logic [63:0]  sl;
  logic [63:0]  perm;
  logic [127:0] k_rot;
  logic [127:0] k_nxt;

  always_comb begin
    ark = s_in ^ k_in[127:64];

    sl = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      sl[4*i +: 4] = sbox(ark[4*i +: 4]);
    end

    // Bit j moves to (16*j) mod 63; bit 63 is a fixed point.
    perm = '0;
    for (int unsigned j = 0; j < 63; j++) begin
      perm[(16 * j) % 63] = sl[j];
    end
    perm[63] = sl[63];
  end

  always_comb begin
    k_rot = {k_in[66:0], k_in[127:67]};
    k_nxt = k_rot;
    k_nxt[127:124] = sbox(k_rot[127:124]);
    k_nxt[123:120] = sbox(k_rot[123:120]);
    k_nxt[66:62]   = k_rot[66:62] ^ rnd;
  end

  logic [63:0]  state_q, state_d;
  logic [127:0] key_q, key_d;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    if (en) begin
      state_d = perm;
      key_d   = k_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
    end
  end

  assign state_out = state_q;
  assign key_out   = key_q;

endmodule

// File: tb/tb_lelbc_round_fn.sv
module tb_lelbc_round_fn;

  logic         clk;
  logic         rst;
  logic         en;
  logic [0:63]  state_in;
  logic [0:127] key_in;
  logic [0:4]   round;
  logic [0:63]  state_out;
  logic [0:127] key_out;

  int checks = 0;
  int errors = 0;

  lelbc_round_fn dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .state_in  (state_in),
    .key_in    (key_in),
    .round     (round),
    .state_out (state_out),
    .key_out   (key_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  // Reference model in LSB-based numbering: bit j of a value is b(j).
  function automatic logic [63:0] m_state(input logic [63:0] s, input logic [127:0] k);
    logic [63:0] t, u, o;
    t = s ^ k[127:64];
    u = '0;
    for (int n = 0; n < 16; n++) begin
      int x;
      x = int'((t >> (4 * n)) & 64'hF);
      u = u | (64'(sb[x]) << (4 * n));
    end
    o = '0;
    for (int j = 0; j < 64; j++) begin
      int p;
      p = (j == 63) ? 63 : (16 * j) % 63;
      if (u[j]) o = o | (64'd1 << p);
    end
    return o;
  endfunction

  function automatic logic [127:0] m_key(input logic [127:0] k, input int r);
    logic [127:0] v;
    int hi, lo;
    v  = (k << 61) | (k >> 67);
    hi = int'(v >> 124);
    lo = int'((v >> 120) & 128'hF);
    v  = (v & ~(128'hFF << 120)) | (128'(sb[hi]) << 124) | (128'(sb[lo]) << 120);
    v  = v ^ (128'(r & 31) << 62);
    return v;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0]  ms, hs;
  logic [127:0] mk, hk;

  initial begin
    // Asynchronous reset before any clock edge.
    rst = 1'b1;
    en = 1'b0;
    state_in = '0;
    key_in = '0;
    round = '0;
    #1;
    check("rst_async_state", 128'(state_out), '0);
    check("rst_async_key", key_out, '0);

    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      state_in = {$urandom, $urandom};
      key_in = {$urandom, $urandom, $urandom, $urandom};
      round = 5'($urandom);
      tick();
      check("idle_en0_state", 128'(state_out), '0);
      check("idle_en0_key", key_out, '0);
    end

    // Zero vector.
    en = 1'b1;
    state_in = '0;
    key_in = '0;
    round = 5'd0;
    tick();
    check("zero_state", 128'(state_out), 128'hFFFFFFFF00000000);
    check("zero_key", key_out, 128'hCC000000000000000000000000000000);

    // Round-counter XOR.
    round = 5'd5;
    tick();
    check("rnd5_state", 128'(state_out), 128'hFFFFFFFF00000000);
    check("rnd5_key", key_out, 128'hCC000000000000014000000000000000);

    // S/P layer on all-ones state.
    state_in = 64'hFFFFFFFFFFFFFFFF;
    round = 5'd0;
    tick();
    check("ones_state", 128'(state_out), 128'h00000000FFFF0000);
    check("ones_key", key_out, 128'hCC000000000000000000000000000000);

    // Hold with en=0.
    state_in = '0;
    key_in = '0;
    round = 5'd0;
    tick();
    en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      state_in = {$urandom, $urandom};
      key_in = {$urandom, $urandom, $urandom, $urandom};
      round = 5'($urandom);
      tick();
      check("hold_state", 128'(state_out), 128'hFFFFFFFF00000000);
      check("hold_key", key_out, 128'hCC000000000000000000000000000000);
    end

    // Asynchronous reset mid-cycle, then reset priority over en.
    en = 1'b1;
    state_in = 64'h0123456789ABCDEF;
    key_in = 128'h00112233445566778899AABBCCDDEEFF;
    round = 5'd9;
    tick();
    check("pre_rst_state", 128'(state_out),
          128'(m_state(64'h0123456789ABCDEF, 128'h00112233445566778899AABBCCDDEEFF)));
    check("pre_rst_key", key_out, m_key(128'h00112233445566778899AABBCCDDEEFF, 9));
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_state", 128'(state_out), '0);
    check("rst_mid_key", key_out, '0);
    tick();
    check("rst_prio_state", 128'(state_out), '0);
    check("rst_prio_key", key_out, '0);
    @(negedge clk);
    rst = 1'b0;

    // 16-round iteration from random vectors, outputs fed back.
    for (int v = 0; v < 4; v++) begin
      ms = {$urandom, $urandom};
      mk = {$urandom, $urandom, $urandom, $urandom};
      state_in = ms;
      key_in = mk;
      for (int r = 0; r < 16; r++) begin
        round = 5'(r);
        hs = m_state(ms, mk);
        hk = m_key(mk, r);
        ms = hs;
        mk = hk;
        tick();
        check($sformatf("iter%0d_r%0d_state", v, r), 128'(state_out), 128'(ms));
        check($sformatf("iter%0d_r%0d_key", v, r), key_out, mk);
        state_in = state_out;
        key_in = key_out;
      end
    end

    // Round values 16..31 are processed like any other.
    for (int c = 0; c < 8; c++) begin
      int r;
      r = 16 + int'($urandom_range(0, 15));
      ms = {$urandom, $urandom};
      mk = {$urandom, $urandom, $urandom, $urandom};
      state_in = ms;
      key_in = mk;
      round = 5'(r);
      tick();
      check($sformatf("hiround%0d_state", r), 128'(state_out), 128'(m_state(ms, mk)));
      check($sformatf("hiround%0d_key", r), key_out, m_key(mk, r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
